uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART byte transmitter between a word requester (A) and a byte requester (B).
// Build option: define UART_TX_ARB_MSB_FIRST_EN to send A words most-significant byte first.

module uart_tx_arbiter #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    a_req,
  input  logic [8*WORD_BYTES-1:0] a_data,
  output logic                    a_ack,
  output logic                    a_done,
  input  logic                    b_req,
  input  logic [7:0]              b_data,
  output logic                    b_ack,
  output logic                    b_done,
  output logic [7:0]              tx_data,
  output logic                    valid,
  input  logic                    tx_done,
  output logic                    busy
);

  localparam int DW     = 8 * WORD_BYTES;
  localparam int RW_MIN = $clog2(WORD_BYTES + 1);
  localparam int RW     = (RW_MIN < 3) ? 3 : RW_MIN;

  localparam logic [RW-1:0] REMAIN_A   = RW'(WORD_BYTES);
  localparam logic [RW-1:0] REMAIN_ONE = {{(RW-1){1'b0}}, 1'b1};
  localparam logic          OWNER_A    = 1'b0;
  localparam logic          OWNER_B    = 1'b1;

  // GRANT carries the ack pulse so that valid lands one cycle after the ack.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q;
  logic [DW-1:0] shift_q;
  logic [RW-1:0] remain_q;
  logic          owner_q;
  logic          last_grant_q;
  logic          tx_done_d_q;
  logic          a_ack_q;
  logic          a_done_q;
  logic          b_ack_q;
  logic          b_done_q;
  logic [7:0]    tx_data_q;
  logic          valid_q;
  logic          busy_q;

  logic          fin_d;
  logic          any_req_d;
  logic          grant_b_d;
  logic [DW-1:0] shift_load_d;
  logic [DW-1:0] shift_adv_d;
  logic [7:0]    cur_byte_d;
  logic [7:0]    next_byte_d;

  // Grant choice, completion edge and byte selection for the current owner.
  always_comb begin
    fin_d     = tx_done_d_q & ~tx_done;
    any_req_d = a_req | b_req;
    if (a_req && b_req) begin
      grant_b_d = ~last_grant_q;
    end else begin
      grant_b_d = b_req;
    end
    if (grant_b_d) begin
      shift_load_d = {{(DW-8){1'b0}}, b_data};
    end else begin
      shift_load_d = a_data;
    end
`ifdef UART_TX_ARB_MSB_FIRST_EN
    if (owner_q == OWNER_A) begin
      shift_adv_d = shift_q << 4'd8;
      cur_byte_d  = shift_q[DW-1 -: 8];
      next_byte_d = shift_adv_d[DW-1 -: 8];
    end else begin
      shift_adv_d = shift_q >> 4'd8;
      cur_byte_d  = shift_q[7:0];
      next_byte_d = shift_adv_d[7:0];
    end
`else
    shift_adv_d = shift_q >> 4'd8;
    cur_byte_d  = shift_q[7:0];
    next_byte_d = shift_adv_d[7:0];
`endif
  end

  // Sequencer with registered handshake and transmitter outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      shift_q      <= {DW{1'b0}};
      remain_q     <= {RW{1'b0}};
      owner_q      <= OWNER_A;
      last_grant_q <= OWNER_B;
      tx_done_d_q  <= 1'b0;
      a_ack_q      <= 1'b0;
      a_done_q     <= 1'b0;
      b_ack_q      <= 1'b0;
      b_done_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      tx_done_d_q <= tx_done;
      a_ack_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_ack_q     <= 1'b0;
      b_done_q    <= 1'b0;
      valid_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            state_q      <= S_GRANT;
            shift_q      <= shift_load_d;
            remain_q     <= grant_b_d ? REMAIN_ONE : REMAIN_A;
            owner_q      <= grant_b_d;
            last_grant_q <= grant_b_d;
            a_ack_q      <= ~grant_b_d;
            b_ack_q      <= grant_b_d;
            busy_q       <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_GRANT: begin
          state_q   <= S_SEND;
          valid_q   <= 1'b1;
          tx_data_q <= cur_byte_d;
        end
        S_SEND: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Only the falling edge of tx_done counts: the transmitter is idle again by then.
          if (fin_d) begin
            if (remain_q == REMAIN_ONE) begin
              state_q  <= S_DONE;
              a_done_q <= (owner_q == OWNER_A);
              b_done_q <= (owner_q == OWNER_B);
            end else begin
              state_q   <= S_SEND;
              shift_q   <= shift_adv_d;
              remain_q  <= remain_q - REMAIN_ONE;
              valid_q   <= 1'b1;
              tx_data_q <= next_byte_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack   = a_ack_q;
  assign a_done  = a_done_q;
  assign b_ack   = b_ack_q;
  assign b_done  = b_done_q;
  assign tx_data = tx_data_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule
